// File: rtl/mini_src_control_unit_if.sv
// Control bundle between the hardwired control unit and the single-bus
// datapath: IR contents and run controls in, bus/register/memory strobes out.
interface mini_src_control_unit_if;
  logic [31:0] ir;
  logic        start;
  logic        stop;
  logic [31:0] enc_input;
  logic [31:0] reg_enable;
  logic [5:0]  ALU_Sel;
  logic        read;
  logic        write;
  logic        incPC;
  logic        Gra;
  logic        Grb;
  logic        Grc;
  logic        Rin;
  logic        Rout;
  logic        BAout;
  logic        conIn;
  logic        run;
  logic        illegal;

  modport master (
    input  ir, start, stop,
    output enc_input, reg_enable, ALU_Sel, read, write, incPC,
           Gra, Grb, Grc, Rin, Rout, BAout, conIn, run, illegal
  );

  modport slave (
    output ir, start, stop,
    input  enc_input, reg_enable, ALU_Sel, read, write, incPC,
           Gra, Grb, Grc, Rin, Rout, BAout, conIn, run, illegal
  );
endinterface

// File: rtl/mini_src_control_unit.sv
// Hardwired Moore control unit for the mini SRC single-bus datapath.
// Sequences fetch and execute for ld, ldi, st, add, sub, and, or, addi,
// nop and halt. Outputs decode from registered state only.
// Optional feature macro: ILLEGAL_TRAP_EN -- when defined, an unlisted
// opcode sets the sticky illegal flag and halts; otherwise it runs as nop.
module mini_src_control_unit #(
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned OP_W     = 5
) (
  input logic                     clock,
  input logic                     clr,
  mini_src_control_unit_if.master bus
);

  // bus source / register enable bit positions
  localparam int unsigned B_Z   = 19;
  localparam int unsigned B_PC  = 20;
  localparam int unsigned B_IR  = 21;
  localparam int unsigned B_MDR = 22;
  localparam int unsigned B_MAR = 23;
  localparam int unsigned B_Y   = 24;
  localparam int unsigned B_C   = 25;

  localparam logic [OP_W-1:0] OP_LD   = OP_W'(5'b00000);
  localparam logic [OP_W-1:0] OP_LDI  = OP_W'(5'b00001);
  localparam logic [OP_W-1:0] OP_ST   = OP_W'(5'b00010);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(5'b00011);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(5'b00100);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(5'b00101);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(5'b00110);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(5'b01100);
  localparam logic [OP_W-1:0] OP_NOP  = OP_W'(5'b11010);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(5'b11011);

  localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT);

  typedef enum logic [4:0] {
    IDLE, F0, F1, FW, F2, F3,
    E3A, E4A, E5A, M1, MW, M2, M3, S1, S2,
    E3R, E4R, E5R, E3I, E4I, E5I,
    HALT
  } state_t;

  state_t          state, state_n, done_tgt;
  logic [3:0]      cnt, cnt_n;
  logic [OP_W-1:0] op_q, op_n;
  logic            illegal_q, ill_n;
  logic [OP_W-1:0] opcode;

  assign opcode = bus.ir[31 -: OP_W];

  // state, wait counter, latched opcode and sticky illegal flag
  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      op_q      <= op_n;
      illegal_q <= ill_n;
    end
  end

  // next-state, counter and opcode latch; opcode is captured at F3 so the
  // execute states never depend combinationally on ir
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    op_n     = op_q;
    ill_n    = illegal_q;
    done_tgt = bus.stop ? IDLE : F0;
    unique case (state)
      IDLE, HALT: if (bus.start) state_n = F0;
      F0: state_n = F1;
      F1: begin
        cnt_n   = WAIT_LOAD;
        state_n = (MEM_WAIT > 0) ? FW : F2;
      end
      FW: begin
        cnt_n = cnt - 4'd1;
        if (cnt <= 4'd1) state_n = F2;
      end
      F2: state_n = F3;
      F3: begin
        op_n = opcode;
        if (opcode == OP_LD || opcode == OP_LDI || opcode == OP_ST)
          state_n = E3A;
        else if (opcode == OP_ADD || opcode == OP_SUB ||
                 opcode == OP_AND || opcode == OP_OR)
          state_n = E3R;
        else if (opcode == OP_ADDI)
          state_n = E3I;
        else if (opcode == OP_NOP)
          state_n = done_tgt;
        else if (opcode == OP_HALT)
          state_n = HALT;
        else begin
`ifdef ILLEGAL_TRAP_EN
          ill_n   = 1'b1;
          state_n = HALT;
`else
          state_n = done_tgt;
`endif
        end
      end
      E3A: state_n = E4A;
      E4A: state_n = E5A;
      E5A: begin
        if (op_q == OP_LD)      state_n = M1;
        else if (op_q == OP_ST) state_n = S1;
        else                    state_n = done_tgt;
      end
      M1: begin
        cnt_n   = WAIT_LOAD;
        state_n = (MEM_WAIT > 0) ? MW : M2;
      end
      MW: begin
        cnt_n = cnt - 4'd1;
        if (cnt <= 4'd1) state_n = M2;
      end
      M2: state_n = M3;
      M3: state_n = done_tgt;
      S1: begin
        cnt_n   = WAIT_LOAD;
        state_n = S2;
      end
      // S2 holds write for MEM_WAIT+1 cycles
      S2: begin
        if (cnt == 4'd0) state_n = done_tgt;
        else             cnt_n   = cnt - 4'd1;
      end
      E3R: state_n = E4R;
      E4R: state_n = E5R;
      E5R: state_n = done_tgt;
      E3I: state_n = E4I;
      E4I: state_n = E5I;
      E5I: state_n = done_tgt;
      default: state_n = IDLE;
    endcase
  end

  // Moore output decode from the registered state
  always_comb begin
    bus.enc_input  = '0;
    bus.reg_enable = '0;
    bus.ALU_Sel    = '0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.incPC      = 1'b0;
    bus.Gra        = 1'b0;
    bus.Grb        = 1'b0;
    bus.Grc        = 1'b0;
    bus.Rin        = 1'b0;
    bus.Rout       = 1'b0;
    bus.BAout      = 1'b0;
    bus.run        = 1'b1;
    unique case (state)
      IDLE, HALT: bus.run = 1'b0;
      F0: begin
        bus.enc_input[B_PC]   = 1'b1;
        bus.reg_enable[B_MAR] = 1'b1;
        bus.reg_enable[B_Z]   = 1'b1;
        bus.incPC             = 1'b1;
      end
      F1: begin
        bus.enc_input[B_Z]   = 1'b1;
        bus.reg_enable[B_PC] = 1'b1;
        bus.read             = 1'b1;
      end
      FW, M1, MW: bus.read = 1'b1;
      F2, M2: begin
        bus.read              = 1'b1;
        bus.reg_enable[B_MDR] = 1'b1;
      end
      F3: begin
        bus.enc_input[B_MDR] = 1'b1;
        bus.reg_enable[B_IR] = 1'b1;
      end
      E3A: begin
        bus.Grb             = 1'b1;
        bus.BAout           = 1'b1;
        bus.reg_enable[B_Y] = 1'b1;
      end
      E4A, E4I: begin
        bus.enc_input[B_C]  = 1'b1;
        bus.reg_enable[B_Z] = 1'b1;
      end
      E5A: begin
        bus.enc_input[B_Z] = 1'b1;
        if (op_q == OP_LD || op_q == OP_ST) begin
          bus.reg_enable[B_MAR] = 1'b1;
        end else begin
          bus.Gra = 1'b1;
          bus.Rin = 1'b1;
        end
      end
      M3: begin
        bus.enc_input[B_MDR] = 1'b1;
        bus.Gra              = 1'b1;
        bus.Rin              = 1'b1;
      end
      S1: begin
        bus.Gra               = 1'b1;
        bus.Rout              = 1'b1;
        bus.reg_enable[B_MDR] = 1'b1;
      end
      S2: bus.write = 1'b1;
      E3R, E3I: begin
        bus.Grb             = 1'b1;
        bus.Rout            = 1'b1;
        bus.reg_enable[B_Y] = 1'b1;
      end
      E4R: begin
        bus.Grc             = 1'b1;
        bus.Rout            = 1'b1;
        bus.reg_enable[B_Z] = 1'b1;
        bus.ALU_Sel         = 6'(op_q - OP_ADD);
      end
      E5R, E5I: begin
        bus.enc_input[B_Z] = 1'b1;
        bus.Gra            = 1'b1;
        bus.Rin            = 1'b1;
      end
      default: bus.run = 1'b0;
    endcase
  end

  assign bus.conIn   = 1'b0;
  assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_mini_src_control_unit.sv
// Bench for mini_src_control_unit. Two instances (MEM_WAIT=1 and 3) share
// clock, reset and stimulus. Each has an instruction-level model that
// expands every fetched opcode into its expected per-cycle output vectors;
// directed windows then pin cycle, read, write and idle counts by hand.
// Honours ILLEGAL_TRAP_EN the same way the design does.
module tb_mini_src_control_unit;

  typedef struct packed {
    logic [31:0] enc;
    logic [31:0] ren;
    logic [5:0]  alu;
    logic rd, wr, inc, gra, grb, grc, rin, rout, ba, con, run, ill;
  } ctl_t;

  typedef struct {
    logic [31:0] iw;
    int          cyc;
    int          rds;
    int          wrs;
    int          idl;
  } vec_t;

  localparam logic [4:0] LD = 5'd0, LDI = 5'd1, ST = 5'd2, ADD = 5'd3,
                         SUB = 5'd4, OP_AND = 5'd5, OP_OR = 5'd6,
                         ADDI = 5'd12, HLT = 5'd27;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        clr   = 1'b0;
  logic [31:0] ir    = '0;
  logic        start = 1'b0;
  logic        stop  = 1'b0;

  int unsigned checks = 0;
  int unsigned passes = 0;

  ctl_t obs [2];

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic ok, input ctl_t act, input ctl_t exp);
    checks++;
    if (ok === 1'b1) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int MW = (g == 0) ? 1 : 3;

    mini_src_control_unit_if bus ();
    assign bus.ir    = ir;
    assign bus.start = start;
    assign bus.stop  = stop;

    mini_src_control_unit #(.MEM_WAIT(MW), .OP_W(5)) dut (
      .clock (clk),
      .clr   (clr),
      .bus   (bus)
    );

    assign obs[g] = {bus.enc_input, bus.reg_enable, bus.ALU_Sel, bus.read,
                     bus.write, bus.incPC, bus.Gra, bus.Grb, bus.Grc, bus.Rin,
                     bus.Rout, bus.BAout, bus.conIn, bus.run, bus.illegal};

    ctl_t q [$];
    ctl_t cur     = '0;
    bit   running = 1'b0;
    bit   in_exec = 1'b0;
    bit   ill     = 1'b0;

    function automatic ctl_t act_v();
      ctl_t c;
      c     = '0;
      c.run = 1'b1;
      return c;
    endfunction

    task automatic push_fetch();
      ctl_t c;
      c = act_v(); c.enc[20] = 1; c.ren[23] = 1; c.ren[19] = 1; c.inc = 1; q.push_back(c);
      c = act_v(); c.enc[19] = 1; c.ren[20] = 1; c.rd = 1; q.push_back(c);
      for (int i = 0; i < MW; i++) begin c = act_v(); c.rd = 1; q.push_back(c); end
      c = act_v(); c.rd = 1; c.ren[22] = 1; q.push_back(c);
      c = act_v(); c.enc[22] = 1; c.ren[21] = 1; q.push_back(c);
    endtask

    task automatic push_exec(input logic [4:0] op);
      ctl_t c;
      if (op == LD || op == LDI || op == ST) begin
        c = act_v(); c.grb = 1; c.ba = 1; c.ren[24] = 1; q.push_back(c);
        c = act_v(); c.enc[25] = 1; c.ren[19] = 1; q.push_back(c);
        c = act_v(); c.enc[19] = 1;
        if (op == LDI) begin c.gra = 1; c.rin = 1; end else c.ren[23] = 1;
        q.push_back(c);
        if (op == LD) begin
          c = act_v(); c.rd = 1; q.push_back(c);
          for (int i = 0; i < MW; i++) begin c = act_v(); c.rd = 1; q.push_back(c); end
          c = act_v(); c.rd = 1; c.ren[22] = 1; q.push_back(c);
          c = act_v(); c.enc[22] = 1; c.gra = 1; c.rin = 1; q.push_back(c);
        end else if (op == ST) begin
          c = act_v(); c.gra = 1; c.rout = 1; c.ren[22] = 1; q.push_back(c);
          for (int i = 0; i <= MW; i++) begin c = act_v(); c.wr = 1; q.push_back(c); end
        end
      end else begin
        c = act_v(); c.grb = 1; c.rout = 1; c.ren[24] = 1; q.push_back(c);
        c = act_v();
        if (op == ADDI) begin
          c.enc[25] = 1; c.ren[19] = 1;
        end else begin
          c.grc = 1; c.rout = 1; c.ren[19] = 1;
          c.alu = (op == SUB) ? 6'd1 : (op == OP_AND) ? 6'd2 : (op == OP_OR) ? 6'd3 : 6'd0;
        end
        q.push_back(c);
        c = act_v(); c.enc[19] = 1; c.gra = 1; c.rin = 1; q.push_back(c);
      end
    endtask

    // instruction-level model: advance on the same edges as the DUT
    always @(posedge clk or negedge clr) begin : model
      ctl_t       nxt;
      logic [4:0] op;
      bit         fin;
      bit         trap_now;
      if (!clr) begin
        q.delete();
        cur     <= '0;
        running <= 1'b0;
        in_exec <= 1'b0;
        ill     <= 1'b0;
      end else begin
        nxt      = '0;
        fin      = 1'b0;
        trap_now = 1'b0;
        if (q.size() != 0) begin
          nxt = q.pop_front();
        end else if (!running) begin
          if (start) begin
            push_fetch();
            nxt = q.pop_front();
            running <= 1'b1;
            in_exec <= 1'b0;
          end
        end else if (!in_exec) begin
          op = ir[31:27];
          if (op == HLT) begin
            running <= 1'b0;
          end else if (op inside {LD, LDI, ST, ADD, SUB, OP_AND, OP_OR, ADDI}) begin
            push_exec(op);
            nxt = q.pop_front();
            in_exec <= 1'b1;
          end else if (TRAP) begin
            trap_now = 1'b1;
            running <= 1'b0;
          end else begin
            fin = 1'b1;
          end
        end else begin
          fin = 1'b1;
        end
        if (fin) begin
          if (stop) begin
            running <= 1'b0;
            in_exec <= 1'b0;
          end else begin
            push_fetch();
            nxt = q.pop_front();
            in_exec <= 1'b0;
          end
        end
        nxt.ill = ill | trap_now;
        ill     <= ill | trap_now;
        cur     <= nxt;
      end
    end

    // per-cycle comparison against the model plus structural invariants
    always @(negedge clk) begin
      check($sformatf("cycle_inst%0d", g), obs[g] === cur, obs[g], cur);
      check($sformatf("enc_onehot_inst%0d", g), $onehot0(obs[g].enc), obs[g], cur);
      check($sformatf("rd_wr_excl_inst%0d", g), !(obs[g].rd && obs[g].wr), obs[g], cur);
      check($sformatf("rin_rout_excl_inst%0d", g), !(obs[g].rin && obs[g].rout), obs[g], cur);
    end
  end

  task automatic wait_f0(input int g);
    int n = 0;
    while (obs[g].inc !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (obs[g].inc !== 1'b1) check_int($sformatf("f0_timeout_inst%0d", g), n, 0);
  endtask

  // from one F0 to the next: cycles, read cycles, write cycles, run=0 cycles
  task automatic measure(input int g, input logic [31:0] iw, input logic stp,
                         output int cyc, output int rds, output int wrs, output int idl);
    bit fin = 1'b0;
    wait_f0(g);
    ir   = iw;
    stop = stp;
    cyc  = 1; rds = 0; wrs = 0; idl = 0;
    while (!fin) begin
      @(negedge clk);
      if (obs[g].inc === 1'b1 || cyc >= 100) fin = 1'b1;
      else begin
        cyc++;
        rds += int'(obs[g].rd);
        wrs += int'(obs[g].wr);
        idl += int'(obs[g].run === 1'b0);
      end
    end
  endtask

  vec_t tbl1 [11] = '{
    '{32'h0080_0055, 12, 6, 0, 0},               // ld
    '{32'h2000_0000,  8, 3, 0, 0},               // sub
    '{32'h1000_0000, 11, 3, 2, 0},               // st
    '{32'h6000_0000,  8, 3, 0, 0},               // addi
    '{32'h0800_0000,  8, 3, 0, 0},               // ldi
    '{32'h2800_0000,  8, 3, 0, 0},               // and
    '{32'h3000_0000,  8, 3, 0, 0},               // or
    '{32'h1800_0000,  8, 3, 0, 0},               // add
    '{32'hD000_0000,  5, 3, 0, 0},               // nop
    '{32'hF800_0000, TRAP ? 6 : 5, 3, 0, TRAP ? 1 : 0}, // unlisted opcode
    '{32'hD800_0000,  6, 3, 0, 1}                // halt, start held high
  };

  initial begin
    int   cyc, rds, wrs, idl;
    ctl_t z, hv, mwv;
    z = '0;

    clr = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_after_reset_inst0", obs[0] === z, obs[0], z);
    check("idle_after_reset_inst1", obs[1] === z, obs[1], z);

    start = 1'b1;
    foreach (tbl1[i]) begin
      measure(0, tbl1[i].iw, 1'b0, cyc, rds, wrs, idl);
      check_int($sformatf("cycles_%h", tbl1[i].iw), cyc, tbl1[i].cyc);
      check_int($sformatf("reads_%h", tbl1[i].iw), rds, tbl1[i].rds);
      check_int($sformatf("writes_%h", tbl1[i].iw), wrs, tbl1[i].wrs);
      check_int($sformatf("idle_%h", tbl1[i].iw), idl, tbl1[i].idl);
      if (i == 9) check_int("illegal_flag", int'(obs[0].ill), int'(TRAP));
    end

    // stop during add: done goes to IDLE for one cycle, start restarts it
    measure(0, 32'h1800_0000, 1'b1, cyc, rds, wrs, idl);
    stop = 1'b0;
    check_int("stop_cycles", cyc, 9);
    check_int("stop_idle", idl, 1);

    // MEM_WAIT=3 instance: st writes for 4 cycles, ld spans 16
    measure(1, 32'h1000_0000, 1'b0, cyc, rds, wrs, idl);
    check_int("st_mw3_cycles", cyc, 15);
    check_int("st_mw3_reads", rds, 5);
    check_int("st_mw3_writes", wrs, 4);
    measure(1, 32'h0080_0055, 1'b0, cyc, rds, wrs, idl);
    check_int("ld_mw3_cycles", cyc, 16);
    check_int("ld_mw3_reads", rds, 10);

    // halt with start low stays halted, then start restarts at F0
    wait_f0(0);
    ir    = 32'hD800_0000;
    start = 1'b0;
    repeat (10) @(negedge clk);
    hv     = '0;
    hv.ill = TRAP;
    check("halt_hold", obs[0] === hv, obs[0], hv);
    start = 1'b1;
    @(negedge clk);
    check_int("halt_restart_f0", int'(obs[0].inc === 1'b1 && obs[0].run === 1'b1), 1);

    // asynchronous reset in the second MW cycle of ld on MEM_WAIT=3
    ir = 32'h0080_0055;
    wait_f0(1);
    repeat (12) @(negedge clk);
    mwv     = '0;
    mwv.rd  = 1'b1;
    mwv.run = 1'b1;
    mwv.ill = obs[1].ill;
    check("mw2_read", obs[1] === mwv, obs[1], mwv);
    #2 clr = 1'b0;
    #1;
    check("async_clr_inst1", obs[1] === z, obs[1], z);
    check("async_clr_inst0", obs[0] === z, obs[0], z);
    start = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_after_clr_inst0", obs[0] === z, obs[0], z);
    check("idle_after_clr_inst1", obs[1] === z, obs[1], z);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
